// File: rtl/clyde_tweakey_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clyde_tweakey_sched_pkg
//  Purpose  : Shared Clyde constants: step count, step index width and the
//             tweakey scheduler FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package clyde_tweakey_sched_pkg;

    localparam int TK_STEPS = 7;
    localparam int STEP_W   = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TK_STEPS - 1);

endpackage : clyde_tweakey_sched_pkg
`default_nettype wire

// File: rtl/clyde_tweakey_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : clyde_tweakey_sched_if
//  Purpose  : Control, key/tweak load and tweakey output bundle of the
//             Clyde tweakey scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface clyde_tweakey_sched_if #(
    parameter int NSHARES = 2
);
    import clyde_tweakey_sched_pkg::*;

    logic                     start;
    logic                     decrypt;
    logic [128*NSHARES-1:0]   key_sh;
    logic [127:0]             tweak;
    logic                     next;
    logic [128*NSHARES-1:0]   tk_sh;
    logic                     tk_valid;
    logic [STEP_W-1:0]        step_idx;
    logic                     last;
    logic                     busy;

    // Consumer side: issues start/next and reads the step tweakey
    modport master (
        output start, decrypt, key_sh, tweak, next,
        input  tk_sh, tk_valid, step_idx, last, busy
    );

    // Scheduler side
    modport slave (
        input  start, decrypt, key_sh, tweak, next,
        output tk_sh, tk_valid, step_idx, last, busy
    );

endinterface : clyde_tweakey_sched_if
`default_nettype wire

// File: rtl/clyde_tweakey_sched_phi_dual.sv
`default_nettype none
// ============================================================================
//  Module   : phi_dual
//  Purpose  : Clyde tweak update phi and its inverse on a {hi,lo} 128-bit
//             tweak. Forward {hi,lo}->{lo,hi^lo}; inverse {hi,lo}->{hi^lo,hi}.
//  Revision : 1.0  initial release
// ============================================================================
module phi_dual (
    input  wire logic [127:0] i_t,
    input  wire logic         i_inv,
    output logic      [127:0] o_t
);

    logic [63:0] w_hi;
    logic [63:0] w_lo;

    assign w_hi = i_t[127:64];
    assign w_lo = i_t[63:0];

    // Select the forward or inverse rotation of the tweak halves
    always_comb begin
        if (i_inv) o_t = {w_hi ^ w_lo, w_hi};
        else       o_t = {w_lo, w_hi ^ w_lo};
    end

endmodule : phi_dual
`default_nettype wire

// File: rtl/clyde_tweakey_sched.sv
`default_nettype none
// ============================================================================
//  Module   : clyde_tweakey_sched
//  Purpose  : Masked Clyde tweakey scheduler. Produces the seven step
//             tweakeys key ^ T(s), with the tweak folded into share 0 only,
//             advancing one step per accepted next request.
//  Revision : 1.0  initial release
// ============================================================================
module clyde_tweakey_sched
    import clyde_tweakey_sched_pkg::*;
#(
    parameter int NSHARES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    clyde_tweakey_sched_if.slave   bus
);

    state_t                  r_state;
    logic [STEP_W-1:0]       r_step;
    logic                    r_dec;
    logic [127:0]            r_t;
    logic [127:0]            r_key0;
    logic [128*NSHARES-1:0]  r_tk_sh;

    logic [127:0]            w_t_nxt;
    logic [128*NSHARES-1:0]  w_tk_load;
    logic                    w_run;

    assign w_run = (r_state == ST_RUN);

    // Single tweak update, direction taken from the registered decrypt bit
    phi_dual u_phi (
        .i_t   (r_t),
        .i_inv (r_dec),
        .o_t   (w_t_nxt)
    );

    // Step-0 tweakey on load: T(0) = tweak enters share 0, other shares pass
    always_comb begin
        w_tk_load          = bus.key_sh;
        w_tk_load[127:0]   = bus.key_sh[127:0] ^ bus.tweak;
    end

    // FSM, step counter and registered tweakey; start overrides next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_dec   <= 1'b0;
            r_t     <= '0;
            r_key0  <= '0;
            r_tk_sh <= '0;
        end else if (bus.start) begin
            r_state <= ST_RUN;
            r_step  <= '0;
            r_dec   <= bus.decrypt;
            r_t     <= bus.tweak;
            r_key0  <= bus.key_sh[127:0];
            r_tk_sh <= w_tk_load;
        end else if (w_run && bus.next) begin
            if (r_step == LAST_STEP) begin
                r_state <= ST_DONE;
            end else begin
                r_step          <= r_step + STEP_W'(1);
                r_t             <= w_t_nxt;
                r_tk_sh[127:0]  <= r_key0 ^ w_t_nxt;
            end
        end
    end

    assign bus.tk_sh    = r_tk_sh;
    assign bus.tk_valid = w_run;
    assign bus.step_idx = r_step;
    assign bus.last     = w_run && (r_step == LAST_STEP);
    assign bus.busy     = w_run;

endmodule : clyde_tweakey_sched
`default_nettype wire

// File: tb/tb_clyde_tweakey_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clyde_tweakey_sched
//  Purpose  : Self-checking bench for clyde_tweakey_sched (NSHARES=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clyde_tweakey_sched;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    clyde_tweakey_sched_if #(.NSHARES(2)) bus ();

    clyde_tweakey_sched #(.NSHARES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tweak update straight from the phi definition
    function automatic logic [127:0] phi_ref(input logic [127:0] t, input logic dec);
        logic [63:0] hi;
        logic [63:0] lo;
        hi = t[127:64];
        lo = t[63:0];
        return dec ? {hi ^ lo, hi} : {lo, hi ^ lo};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 256'(bus.tk_valid), 256'(0));
        check({tag, "_last"},  256'(bus.last),     256'(0));
        check({tag, "_busy"},  256'(bus.busy),     256'(0));
    endtask

    // Full expected step tweakey for step s of a schedule
    task automatic check_step(input string tag, input int s, input logic [255:0] key,
                              input logic [127:0] t);
        check({tag, "_valid"}, 256'(bus.tk_valid), 256'(1));
        check({tag, "_busy"},  256'(bus.busy),     256'(1));
        check({tag, "_idx"},   256'(bus.step_idx), 256'(s));
        check({tag, "_last"},  256'(bus.last),     256'(s == 6));
        check({tag, "_sh0"},   256'(bus.tk_sh[127:0]),   256'(key[127:0] ^ t));
        check({tag, "_sh1"},   256'(bus.tk_sh[255:128]), 256'(key[255:128]));
        check({tag, "_xor"},   256'(bus.tk_sh[127:0] ^ bus.tk_sh[255:128]),
              256'(key[127:0] ^ key[255:128] ^ t));
    endtask

    task automatic do_start(input logic dec, input logic [255:0] key, input logic [127:0] t);
        bus.start   = 1'b1;
        bus.decrypt = dec;
        bus.key_sh  = key;
        bus.tweak   = t;
        tick();
        bus.start   = 1'b0;
        bus.decrypt = $urandom_range(0, 1);
        bus.key_sh  = {8{$urandom}};
        bus.tweak   = {4{$urandom}};
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        logic [127:0] vec_t [7];
        logic [127:0] exp_t [7];
        logic [255:0] key;
        logic [127:0] tw;
        logic         dec;
        int           s;

        total = 0;
        bad   = 0;
        bus.start = 1'b0; bus.next = 1'b0; bus.decrypt = 1'b0;
        bus.key_sh = '0; bus.tweak = '0;
        rst_n = 1'b0;
        #12;
        check("rst_tk_sh", bus.tk_sh, 256'(0));
        check("rst_idx", 256'(bus.step_idx), 256'(0));
        check_idle("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // next in IDLE is ignored
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check_idle("idle_next");
        check("idle_next_idx", 256'(bus.step_idx), 256'(0));

        // Encryption known vectors
        vec_t[0] = {64'h1, 64'h2}; vec_t[1] = {64'h2, 64'h3}; vec_t[2] = {64'h3, 64'h1};
        vec_t[3] = {64'h1, 64'h2}; vec_t[4] = {64'h2, 64'h3}; vec_t[5] = {64'h3, 64'h1};
        vec_t[6] = {64'h1, 64'h2};
        do_start(1'b0, '0, {64'h1, 64'h2});
        for (int i = 0; i < 7; i++) begin
            check_step($sformatf("enc_s%0d", i), i, '0, vec_t[i]);
            bus.next = 1'b1;
            tick();
            bus.next = 1'b0;
        end
        check_idle("enc_done");
        check("enc_done_idx", 256'(bus.step_idx), 256'(6));
        bus.next = 1'b1;
        tick(); tick();
        bus.next = 1'b0;
        check_idle("done_next");

        // Decryption known vectors
        vec_t[1] = {64'h3, 64'h1}; vec_t[2] = {64'h2, 64'h3};
        do_start(1'b1, '0, {64'h1, 64'h2});
        for (int i = 0; i < 3; i++) begin
            check_step($sformatf("dec_s%0d", i), i, '0, vec_t[i]);
            bus.next = 1'b1;
            tick();
            bus.next = 1'b0;
        end

        // Randomized schedules with idle gaps between next requests
        for (int run = 0; run < 4; run++) begin
            key = rand_key();
            tw  = {$urandom, $urandom, $urandom, $urandom};
            dec = run[0];
            exp_t[0] = tw;
            for (int i = 1; i < 7; i++) exp_t[i] = phi_ref(exp_t[i-1], dec);
            do_start(dec, key, tw);
            s = 0;
            while (s < 7) begin
                check_step($sformatf("rnd%0d_s%0d", run, s), s, key, exp_t[s]);
                bus.next = ($urandom_range(0, 2) != 0);
                tick();
                if (bus.next) s++;
                bus.next = 1'b0;
            end
            check_idle($sformatf("rnd%0d_done", run));
        end

        // Restart at step 3 with start and next together
        key = rand_key();
        do_start(1'b0, key, {64'h1, 64'h2});
        for (int i = 0; i < 3; i++) begin
            bus.next = 1'b1;
            tick();
        end
        check("pre_restart_idx", 256'(bus.step_idx), 256'(3));
        tw = {$urandom, $urandom, $urandom, $urandom};
        bus.next = 1'b1;
        do_start(1'b0, key, tw);
        bus.next = 1'b0;
        check_step("restart", 0, key, tw);

        // Asynchronous reset in the middle of step 4
        for (int i = 0; i < 4; i++) begin
            bus.next = 1'b1;
            tick();
        end
        bus.next = 1'b0;
        check("pre_rst_idx", 256'(bus.step_idx), 256'(4));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tk_sh", bus.tk_sh, 256'(0));
        check("arst_idx", 256'(bus.step_idx), 256'(0));
        check_idle("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_rst");
        key = rand_key();
        tw  = {$urandom, $urandom, $urandom, $urandom};
        do_start(1'b1, key, tw);
        check_step("post_rst_s0", 0, key, tw);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check_step("post_rst_s1", 1, key, phi_ref(tw, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_clyde_tweakey_sched
`default_nettype wire

// File: doc/clyde_tweakey_sched.md
CLYDE_TWEAKEY_SCHED -- requirements
Module: clyde_tweakey_sched

Interface
REQ-001 Parameter NSHARES, default 2: number of Boolean key shares (min 1).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle pulse that loads key/tweak and begins a schedule.
REQ-005 decrypt  input  1  direction, sampled with start; 1 selects the inverse tweak update.
REQ-006 key_sh  input  128*NSHARES  masked key, share i on bits [128*i+127:128*i]; sampled with start.
REQ-007 tweak  input  128  public tweak; [127:64]=t1, [63:0]=t0; sampled with start.
REQ-008 next  input  1  consumer request to advance to the following step tweakey.
REQ-009 tk_sh  output  128*NSHARES  masked tweakey for the current step, registered.
REQ-010 tk_valid  output  1  tk_sh holds a valid step tweakey.
REQ-011 step_idx  output  3  index of the current step tweakey, 0..6.
REQ-012 last  output  1  high while tk_valid and step_idx==6.
REQ-013 busy  output  1  high in RUN.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-015 start in any state SHALL load the key shares and tweak into registers, clear step_idx and enter RUN on the next edge.
REQ-016 tk_valid SHALL rise exactly one cycle after start and remain high throughout RUN.
REQ-017 Step tweakey: tk_sh share 0 = key share 0 XOR T(s); shares 1..NSHARES-1 = key shares unchanged.
REQ-018 Forward phi on {hi,lo}: {hi,lo} -> {lo, hi^lo}; inverse phi: {hi,lo} -> {hi^lo, hi}; phi^3 = identity.
REQ-019 T(0) = tweak in both directions; encryption uses T(s+1)=phi(T(s)), decryption uses T(s+1)=phi_inv(T(s)).
REQ-020 next with tk_valid and step_idx<6 SHALL advance step_idx by 1 and update tk_sh on the next edge (one-cycle latency).
REQ-021 next with last high SHALL move to DONE; tk_valid and last fall on the next edge.
REQ-022 next in IDLE or DONE SHALL be ignored.
REQ-023 start and next in the same cycle: start wins; the schedule restarts at step 0.
REQ-024 step_idx SHALL never exceed 6 and SHALL not wrap.
REQ-025 No combinational path from any input to any output.
REQ-026 Shares SHALL never be XORed together; the tweak enters share 0 only.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, tk_valid=0, last=0, busy=0, step_idx=0 and tk_sh=0, including mid-schedule.
REQ-028 The first start after rst_n release SHALL behave as from power-up.

Structure
REQ-029 The shared Clyde package SHALL hold TK_STEPS=7, the step index width, and the FSM state typedef.
REQ-030 The tweak update SHALL instantiate the existing phi_dual block once, with its inverse input driven by the registered direction bit.
REQ-031 Target size: 120-400 lines of RTL.

Verification
REQ-032 Encryption: key=0, tweak={64'h1,64'h2}, start -> steps 0..3 give T={1,2},{2,3},{3,1},{1,2}; step 6 equals step 0.
REQ-033 Decryption: same stimulus with decrypt=1 -> steps 0..2 give T={1,2},{3,1},{2,3}.
REQ-034 Masking, NSHARES=2: random key shares -> XOR of the tk_sh shares equals key^T(s) at every step; share 1 always equals key share 1.
REQ-035 Full run: 6 next pulses reach last=1; a 7th next -> tk_valid=0 and DONE; further next ignored.
REQ-036 Restart: at step 3, start and next asserted together -> step_idx=0 next cycle with the newly loaded tweak.
REQ-037 Reset: rst_n low at step 4 -> all outputs 0 asynchronously; after release, start gives step 0 one cycle later.
